// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shift mode encodings shared by the ALU datapath
// Contents: MODE_W (width of a shift mode code), shift_mode_e (LSR/ASR/LSL/ROR).
package alu_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        SH_LSR = 2'b00,
        SH_ASR = 2'b01,
        SH_LSL = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one registered conditional 2^STAGE_IDX shift with sideband
// Ports: clk, rst_n (async, active low), en (advance strobe);
//        in_valid/in_data/in_shamt/in_mode/in_sign/in_tag  - slot entering this stage;
//        out_valid/out_data/out_shamt/out_mode/out_sign/out_tag - registered slot;
//        out_zero - registered flag, out_data == 0.
module shift_stage
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SHAMT_W   = 4,
    parameter int TAG_W     = 4,
    parameter int STAGE_IDX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  shift_mode_e        in_mode,
    input  logic               in_sign,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output shift_mode_e        out_mode,
    output logic               out_sign,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero
);

    localparam int SH = 1 << STAGE_IDX;

    logic [WIDTH-1:0] d_nxt;

    always_comb begin
        d_nxt = in_data;
        if (in_shamt[STAGE_IDX]) begin
            case (in_mode)
                SH_LSR:  d_nxt = in_data >> SH;
                // Fill comes from the sign captured at the pipe entrance, not the
                // current MSB, so it stays correct however far the data has moved.
                SH_ASR:  d_nxt = (in_data >> SH) | ({WIDTH{in_sign}} & ~({WIDTH{1'b1}} >> SH));
                SH_LSL:  d_nxt = in_data << SH;
                SH_ROR:  d_nxt = (in_data >> SH) | (in_data << (WIDTH - SH));
                default: d_nxt = in_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_mode  <= SH_LSR;
            out_sign  <= 1'b0;
            out_tag   <= '0;
            out_zero  <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= d_nxt;
            out_shamt <= in_shamt;
            out_mode  <= in_mode;
            out_sign  <= in_sign;
            out_tag   <= in_tag;
            out_zero  <= (d_nxt == '0);
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - log2(WIDTH)-stage pipelined LSR/ASR/LSL/ROR shifter
// Ports: clk, rst_n (async, active low);
//        in_valid/in_ready/in_data/in_shamt/in_mode/in_tag - operand stream;
//        out_valid/out_ready/out_data/out_tag/out_zero      - result stream.
// in_shamt MSB marks an overshift (amount >= WIDTH); latency is SHAMT_W cycles.
module pipelined_barrel_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W:0]   in_shamt,
    input  logic [MODE_W-1:0]  in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero
);

    // The whole pipe moves as one; it only stops when a finished result is
    // waiting on the output and the consumer refuses it.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    shift_mode_e         pd_mode;
    logic                pd_sign;
    logic [WIDTH-1:0]    pd_data;
    logic [SHAMT_W-1:0]  pd_shamt;

    // Overshift is folded into the operand before stage 0 so the stages never
    // need to know about it: zero/sign-fill results become a no-shift of a
    // preset value, and rotate simply drops the MSB (mod WIDTH).
    always_comb begin
        pd_mode  = shift_mode_e'(in_mode);
        pd_sign  = in_data[WIDTH-1];
        pd_data  = in_data;
        pd_shamt = in_shamt[SHAMT_W-1:0];
        if (in_shamt[SHAMT_W]) begin
            case (pd_mode)
                SH_LSR, SH_LSL: begin
                    pd_data  = '0;
                    pd_shamt = '0;
                end
                SH_ASR: begin
                    pd_data  = {WIDTH{pd_sign}};
                    pd_shamt = '0;
                end
                default: ;
            endcase
        end
    end

    logic               v_s  [SHAMT_W];
    logic [WIDTH-1:0]   d_s  [SHAMT_W];
    logic [SHAMT_W-1:0] sh_s [SHAMT_W];
    shift_mode_e        m_s  [SHAMT_W];
    logic               sg_s [SHAMT_W];
    logic [TAG_W-1:0]   t_s  [SHAMT_W];
    logic [SHAMT_W-1:0] z_s;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic               vi;
        logic [WIDTH-1:0]   di;
        logic [SHAMT_W-1:0] shi;
        shift_mode_e        mi;
        logic               sgi;
        logic [TAG_W-1:0]   ti;

        if (k == 0) begin : g_first
            assign vi  = in_valid;
            assign di  = pd_data;
            assign shi = pd_shamt;
            assign mi  = pd_mode;
            assign sgi = pd_sign;
            assign ti  = in_tag;
        end else begin : g_next
            assign vi  = v_s[k-1];
            assign di  = d_s[k-1];
            assign shi = sh_s[k-1];
            assign mi  = m_s[k-1];
            assign sgi = sg_s[k-1];
            assign ti  = t_s[k-1];
        end

        shift_stage #(
            .WIDTH    (WIDTH),
            .SHAMT_W  (SHAMT_W),
            .TAG_W    (TAG_W),
            .STAGE_IDX(k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .in_valid (vi),
            .in_data  (di),
            .in_shamt (shi),
            .in_mode  (mi),
            .in_sign  (sgi),
            .in_tag   (ti),
            .out_valid(v_s[k]),
            .out_data (d_s[k]),
            .out_shamt(sh_s[k]),
            .out_mode (m_s[k]),
            .out_sign (sg_s[k]),
            .out_tag  (t_s[k]),
            .out_zero (z_s[k])
        );
    end

    assign out_valid = v_s[SHAMT_W-1];
    assign out_data  = d_s[SHAMT_W-1];
    assign out_tag   = t_s[SHAMT_W-1];
    assign out_zero  = z_s[SHAMT_W-1];

    // Sideband leaving the last stage and the zero flags of inner stages have no consumer.
    logic unused_tail;
    assign unused_tail = ^{z_s[SHAMT_W-2:0], sh_s[SHAMT_W-1], m_s[SHAMT_W-1], sg_s[SHAMT_W-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - self-checking bench, WIDTH 16 and 32 instances
module tb_pipelined_barrel_shifter;

    localparam int NRAND = 10000;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  t;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        vi  [2];
    logic        ri  [2];
    logic [31:0] di  [2];
    logic [5:0]  si  [2];
    logic [1:0]  mi  [2];
    logic [3:0]  ti  [2];
    logic        vo  [2];
    logic        ro  [2];
    logic [31:0] dout[2];
    logic [3:0]  to  [2];
    logic        zo  [2];
    logic [15:0] d16;
    logic [31:0] d32;

    int total;
    int bad;

    assign dout[0] = {16'h0, d16};
    assign dout[1] = d32;

    pipelined_barrel_shifter #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vi[0]), .in_ready(ri[0]), .in_data(di[0][15:0]), .in_shamt(si[0][4:0]),
        .in_mode(mi[0]), .in_tag(ti[0]),
        .out_valid(vo[0]), .out_ready(ro[0]), .out_data(d16), .out_tag(to[0]), .out_zero(zo[0])
    );

    pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vi[1]), .in_ready(ri[1]), .in_data(di[1]), .in_shamt(si[1]),
        .in_mode(mi[1]), .in_tag(ti[1]),
        .out_valid(vo[1]), .out_ready(ro[1]), .out_data(d32), .out_tag(to[1]), .out_zero(zo[1])
    );

    always #5 clk = ~clk;

    // Reference: the mathematical meaning of each mode on a w-bit operand.
    function automatic logic [31:0] ref_shift(input int w, input logic [31:0] d, input int sh, input int mode);
        longint unsigned mask, x, r;
        int s;
        mask = (64'd1 << w) - 1;
        x = {32'h0, d} & mask;
        case (mode)
            0: r = (sh >= w) ? 64'd0 : (x >> sh);
            1: begin
                s = (sh >= w) ? w : sh;
                r = x >> s;
                if (((x >> (w - 1)) & 1) != 0) r = r | (mask & ~(mask >> s));
            end
            2: r = (sh >= w) ? 64'd0 : ((x << sh) & mask);
            default: begin
                s = sh % w;
                r = ((x >> s) | (x << (w - s))) & mask;
            end
        endcase
        return r[31:0];
    endfunction

    // Drive one operand with out_ready high and wait for its result.
    task automatic run_op(input int u, input logic [31:0] d, input int sh, input int mode, input int tag,
                          output logic [31:0] res, output logic [3:0] rtag, output logic rzero, output int lat);
        @(negedge clk);
        vi[u] = 1'b1; di[u] = d; si[u] = sh[5:0]; mi[u] = mode[1:0]; ti[u] = tag[3:0]; ro[u] = 1'b1;
        @(negedge clk);
        vi[u] = 1'b0;
        lat = 1;
        while (vo[u] !== 1'b1 && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        if (vo[u] !== 1'b1) lat = -1;
        res = dout[u]; rtag = to[u]; rzero = zo[u];
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        for (int u = 0; u < 2; u++) begin
            total++;
            if (vo[u] !== 1'b0 || dout[u] !== 32'h0 || to[u] !== 4'h0 || zo[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs u=%0d: valid=%b data=%h tag=%h zero=%b want all 0", u, vo[u], dout[u], to[u], zo[u]);
            end
            total++;
            if (ri[u] !== 1'b1) begin bad++; $display("FAIL reset_in_ready u=%0d: got %b want 1", u, ri[u]); end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if (vo[u] !== 1'b0 || ri[u] !== 1'b1) begin
                bad++;
                $display("FAIL post_reset u=%0d: valid=%b ready=%b want 0/1", u, vo[u], ri[u]);
            end
        end
    endtask

    task automatic test_lsr;
        logic [31:0] r; logic [3:0] t; logic z; int lat;
        run_op(0, 32'hF0F0, 4, 0, 5, r, t, z, lat);
        total++; if (r !== 32'h0F0F) begin bad++; $display("FAIL lsr_data: got %h want 0f0f", r); end
        total++; if (z !== 1'b0) begin bad++; $display("FAIL lsr_zero: got %b want 0", z); end
        total++; if (t !== 4'd5) begin bad++; $display("FAIL lsr_tag: got %0d want 5", t); end
        total++; if (lat != 4) begin bad++; $display("FAIL lsr_latency: got %0d want 4", lat); end
    endtask

    task automatic test_asr_overshift;
        logic [31:0] r; logic [3:0] t; logic z; int lat;
        run_op(0, 32'h8001, 15, 1, 1, r, t, z, lat);
        total++; if (r !== 32'hFFFF) begin bad++; $display("FAIL asr15: got %h want ffff", r); end
        run_op(0, 32'h8001, 16, 1, 2, r, t, z, lat);
        total++; if (r !== 32'hFFFF || z !== 1'b0) begin bad++; $display("FAIL asr16: got %h/%b want ffff/0", r, z); end
        run_op(0, 32'h8001, 16, 0, 3, r, t, z, lat);
        total++; if (r !== 32'h0 || z !== 1'b1) begin bad++; $display("FAIL lsr16: got %h/%b want 0000/1", r, z); end
        run_op(0, 32'h7001, 31, 1, 4, r, t, z, lat);
        total++; if (r !== 32'h0 || z !== 1'b1) begin bad++; $display("FAIL asr31_pos: got %h/%b want 0000/1", r, z); end
    endtask

    task automatic test_ror_lsl_zero;
        logic [31:0] r; logic [3:0] t; logic z; int lat;
        run_op(0, 32'h1234, 20, 3, 6, r, t, z, lat);
        total++; if (r !== 32'h4123) begin bad++; $display("FAIL ror20: got %h want 4123", r); end
        run_op(0, 32'h0001, 15, 2, 7, r, t, z, lat);
        total++; if (r !== 32'h8000) begin bad++; $display("FAIL lsl15: got %h want 8000", r); end
        for (int m = 0; m < 4; m++) begin
            run_op(0, 32'hA5A5, 0, m, m, r, t, z, lat);
            total++;
            if (r !== 32'hA5A5 || t !== m[3:0]) begin
                bad++;
                $display("FAIL shamt0 mode=%0d: got %h tag %0d want a5a5 tag %0d", m, r, t, m);
            end
        end
    endtask

    task automatic test_width32;
        logic [31:0] r; logic [3:0] t; logic z; int lat;
        run_op(1, 32'h8000_0000, 31, 0, 9, r, t, z, lat);
        total++; if (r !== 32'h1 || lat != 5) begin bad++; $display("FAIL w32_lsr31: got %h lat %0d want 1 lat 5", r, lat); end
        run_op(1, 32'h8000_0000, 40, 1, 10, r, t, z, lat);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL w32_asr40: got %h want ffffffff", r); end
        run_op(1, 32'h1234_5678, 36, 3, 11, r, t, z, lat);
        total++; if (r !== 32'h8123_4567) begin bad++; $display("FAIL w32_ror36: got %h want 81234567", r); end
    endtask

    task automatic test_backpressure;
        item_t q[$];
        item_t it;
        int sent, got, stall_cycles;
        logic held;
        logic [31:0] hd, d;
        logic [3:0] ht;
        int sh, md;
        sent = 0; got = 0; stall_cycles = 0; held = 1'b0; hd = '0; ht = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            if (held) begin
                total++;
                if (vo[0] !== 1'b1 || dout[0] !== hd || to[0] !== ht) begin
                    bad++;
                    $display("FAIL bp_hold: valid=%b data=%h tag=%0d want 1 %h %0d", vo[0], dout[0], to[0], hd, ht);
                end
            end
            d = $urandom & 32'hFFFF; sh = $urandom_range(0, 31); md = $urandom_range(0, 3);
            vi[0] = (sent < 8); di[0] = d; si[0] = sh[5:0]; mi[0] = md[1:0]; ti[0] = sent[3:0];
            ro[0] = !(c >= 6 && c < 9);
            #1;
            if (!ro[0] && vo[0] === 1'b1) begin
                stall_cycles++;
                total++;
                if (ri[0] !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0 at cycle %0d", ri[0], c); end
            end
            if (vo[0] === 1'b1 && ro[0]) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_extra: result tag %0d with nothing outstanding", to[0]);
                end else begin
                    it = q.pop_front();
                    if (dout[0] !== it.d || to[0] !== it.t || to[0] !== got[3:0]) begin
                        bad++;
                        $display("FAIL bp_result: got %h tag %0d want %h tag %0d", dout[0], to[0], it.d, it.t);
                    end
                end
                got++;
            end
            held = (vo[0] === 1'b1) && !ro[0];
            hd = dout[0]; ht = to[0];
            if (vi[0] && ri[0] === 1'b1) begin
                q.push_back('{ref_shift(16, d, sh, md), sent[3:0]});
                sent++;
            end
        end
        vi[0] = 1'b0; ro[0] = 1'b1;
        total++;
        if (got != 8 || q.size() != 0 || stall_cycles != 3) begin
            bad++;
            $display("FAIL bp_count: delivered %0d left %0d stalls %0d want 8 0 3", got, q.size(), stall_cycles);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; logic [3:0] t; logic z; int lat; int quiet_bad;
        ro[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vi[0] = 1'b1; di[0] = 32'h100 + i; si[0] = 6'd1; mi[0] = 2'd0; ti[0] = i[3:0];
        end
        @(negedge clk);
        vi[0] = 1'b0;
        @(negedge clk);
        total++;
        if (vo[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_pre: valid=%b want 1", vo[0]); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (vo[0] !== 1'b0 || dout[0] !== 32'h0 || zo[0] !== 1'b0 || to[0] !== 4'h0) begin
            bad++;
            $display("FAIL rst_mid_async: valid=%b data=%h zero=%b tag=%h want all 0", vo[0], dout[0], zo[0], to[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vo[0] !== 1'b0) quiet_bad++;
        end
        total++;
        if (quiet_bad != 0) begin bad++; $display("FAIL rst_mid_quiet: valid seen in %0d cycles want 0", quiet_bad); end
        run_op(0, 32'h00F0, 4, 0, 12, r, t, z, lat);
        total++;
        if (r !== 32'h000F || t !== 4'd12 || lat != 4) begin
            bad++;
            $display("FAIL rst_mid_after: got %h tag %0d lat %0d want 000f tag 12 lat 4", r, t, lat);
        end
    endtask

    task automatic test_random(input int u);
        item_t q[$];
        item_t it;
        int w, sent, cyc, sh, md;
        logic held, er;
        logic [31:0] hd, d;
        logic [3:0] ht;
        w = (u != 0) ? 32 : 16;
        sent = 0; cyc = 0; held = 1'b0; hd = '0; ht = '0;
        while ((sent < NRAND || q.size() != 0) && cyc < NRAND * 8) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                total++;
                if (vo[u] !== 1'b1 || dout[u] !== hd || to[u] !== ht) begin
                    bad++;
                    $display("FAIL rnd_hold w=%0d: valid=%b data=%h tag=%0d want 1 %h %0d", w, vo[u], dout[u], to[u], hd, ht);
                end
            end
            d = $urandom;
            if (w == 16) d = d & 32'hFFFF;
            sh = $urandom_range(0, 2 * w - 1);
            md = $urandom_range(0, 3);
            vi[u] = (sent < NRAND) && ($urandom_range(0, 7) != 0);
            di[u] = d; si[u] = sh[5:0]; mi[u] = md[1:0]; ti[u] = sent[3:0];
            ro[u] = ($urandom_range(0, 3) != 0);
            #1;
            er = (vo[u] !== 1'b1) || ro[u];
            total++;
            if (ri[u] !== er) begin bad++; $display("FAIL rnd_in_ready w=%0d: got %b want %b", w, ri[u], er); end
            if (vo[u] === 1'b1 && ro[u]) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd_extra w=%0d: result %h with nothing outstanding", w, dout[u]);
                end else begin
                    it = q.pop_front();
                    if (dout[u] !== it.d || to[u] !== it.t || zo[u] !== (it.d == 32'h0)) begin
                        bad++;
                        $display("FAIL rnd_result w=%0d: got %h tag %0d zero %b want %h tag %0d", w, dout[u], to[u], zo[u], it.d, it.t);
                    end
                end
            end
            held = (vo[u] === 1'b1) && !ro[u];
            hd = dout[u]; ht = to[u];
            if (vi[u] && ri[u] === 1'b1) begin
                q.push_back('{ref_shift(w, d, sh, md), sent[3:0]});
                sent++;
            end
        end
        vi[u] = 1'b0; ro[u] = 1'b1;
        total++;
        if (sent != NRAND || q.size() != 0) begin
            bad++;
            $display("FAIL rnd_drain w=%0d: sent %0d outstanding %0d after %0d cycles", w, sent, q.size(), cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        total = 0;
        bad = 0;
        for (int u = 0; u < 2; u++) begin
            vi[u] = 1'b0; di[u] = '0; si[u] = '0; mi[u] = '0; ti[u] = '0; ro[u] = 1'b1;
        end
        test_reset;
        test_lsr;
        test_asr_overshift;
        test_ror_lsl_zero;
        test_width32;
        test_backpressure;
        test_reset_mid;
        test_random(0);
        test_random(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter. It is the next-generation replacement for the fixed 16-bit combinational logical-right shifter in the ALU datapath.
- Supports four modes: logical right, arithmetic right, logical left and rotate right.
- Operand width is configurable.
- Shifts by 2^k in stage k of a log2(WIDTH)-deep register pipeline.
- Uses a valid/ready handshake on both sides, so it drops into the accelerator's streaming vector lanes.

Parameters:
- WIDTH, 16, operand width in bits. Power of two, at least 4.
- SHAMT_W, $clog2(WIDTH), number of pipeline stages. Equals the latency in cycles. Derived; do not override.
- TAG_W, 4, width of the user tag carried alongside each operand.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  shifter can accept an operand this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W+1  shift amount, 0..2*WIDTH-1. The MSB flags an overshift.
- in_mode  in  2  shift mode: 00 LSR, 01 ASR, 10 LSL, 11 ROR
- in_tag  in  TAG_W  opaque tag, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of the result
- out_zero  out  1  out_data == 0

Behaviour:
- Reset (async, rst_n low):
  - All stage valid bits, out_valid, out_data, out_tag and out_zero clear to 0 immediately.
  - in_ready is 1 while reset is low and after release.
- Advance enable: en = !out_valid || out_ready. All stages advance together when en = 1 and hold when en = 0.
- in_ready = en, so in_ready is combinational from out_ready.
- Accept rule: an operand is accepted when in_valid && in_ready.
- Latency and throughput:
  - An operand accepted in cycle N appears on out_valid in cycle N+SHAMT_W, provided no stall occurs in between.
  - Throughput is one operand per cycle.
  - Bubbles (in_valid = 0) propagate as invalid slots.
- Stage k (k = 0..SHAMT_W-1): if the effective shamt bit k is 1, shift by 2^k per mode.
  - LSR and LSL fill with 0.
  - ASR fills with the operand's original MSB, captured at input and carried down the pipe.
  - ROR wraps the bits around.
  - Mode, sign bit, remaining shamt bits and tag travel with the data through every stage.
- Overshift (in_shamt >= WIDTH, i.e. the MSB is set), resolved at stage 0 before any shifting:
  - LSR, LSL: the result is all zeros.
  - ASR: the result is all copies of the sign bit.
  - ROR: uses in_shamt mod WIDTH (MSB ignored).
- in_shamt == 0 in any mode: result equals the operand.
- out_zero is registered with out_data, in the same cycle.
- Stall (out_valid && !out_ready):
  - out_data, out_tag and out_zero hold stable.
  - No stage updates and no operand is lost or duplicated.
- Order: results emerge in acceptance order.
- Reset mid-operation: all in-flight operands are discarded. After release, out_valid stays 0 until a new operand has traversed the pipe.
- Input signals are ignored when in_valid = 0. Stage data registers may update with don't-care values while their valid bit is 0.

Decomposition:
- Shared package alu_pkg:
  - shift_mode_e enum: SH_LSR = 2'b00, SH_ASR = 2'b01, SH_LSL = 2'b10, SH_ROR = 2'b11.
  - MODE_W = 2.
- Sub-module shift_stage:
  - Parameters WIDTH, SHAMT_W, TAG_W, STAGE_IDX.
  - Implements one registered 2^STAGE_IDX conditional shift, with sideband payload and enable.
  - The top generates SHAMT_W instances plus the overshift pre-decode and the en logic.

Test Plan:
1. LSR, in_data = 0xF0F0, shamt = 4 → out_data = 0x0F0F, out_zero = 0, exactly 4 cycles after acceptance, tag echoed.
2. ASR, 0x8001:
   - shamt = 15 → 0xFFFF.
   - shamt = 16 → 0xFFFF.
   - LSR 0x8001 with shamt = 16 → 0x0000 with out_zero = 1.
3. ROR, 0x1234, shamt = 20 → 0x4123. LSL, 0x0001, shamt = 15 → 0x8000. Any mode with shamt = 0 on 0xA5A5 → 0xA5A5.
4. Backpressure:
   - Stimulus: 8 back-to-back operands with tags 0..7; out_ready held low for 3 cycles at cycle 6.
   - Required: in_ready is low during the stall, outputs are held stable, and all 8 results are delivered in tag order with none dropped or duplicated.
5. Reset mid-stream: rst_n pulsed low with 3 operands in flight → out_valid drops to 0 asynchronously, and nothing is emitted after release until new input arrives.
6. Random regression: 10k random operands, modes, shamts and out_ready patterns, checked against a reference model at WIDTH = 16 and WIDTH = 32.
